bf16_to_fp8_stream: RTL and testbench
=====================================

Name: bf16_to_fp8_stream

Overview:
- Pipelined, multi-lane BF16-to-FP8 converter with a valid/ready stream interface.
- Per-beat selectable output format: E4M3 or E5M2.
- Selectable rounding mode and saturation mode.
- Produces FP8 subnormals with correct rounding, and reports per-lane exception flags plus a saturating overflow counter.
- Sits between the BF16 accumulator/activation path and the FP8 weight/activation buffers.

Parameters:
- LANES, 4, number of BF16 elements converted per beat.
- CNT_W, 16, width of the overflow event counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: asynchronous, active-low.
- cfg_fmt  in  1  output format: 0 = E4M3 (bias 7), 1 = E5M2 (bias 15).
- cfg_rnd  in  1  rounding: 0 = round-to-nearest-even, 1 = truncate toward zero.
- cfg_sat  in  1  overflow handling: 1 = saturate to max finite, 0 = non-saturating (Inf/NaN).
- in_valid  in  1  input beat valid.
- in_ready  out  1  converter can accept a beat.
- in_data  in  LANES*16  BF16 lanes; lane i = bits [16i+15:16i].
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*8  FP8 lanes; lane i = bits [8i+7:8i].
- out_flags  out  LANES*2  per lane {ovf, unf}.
- ovf_cnt  out  CNT_W  saturating count of lanes with ovf=1.
- cnt_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_flags=0, ovf_cnt=0, pipeline valid bits cleared. in_ready=1 one cycle after reset release.
- Reset mid-operation discards all in-flight beats; no partial beat is emitted.
- Pipeline:
  - Two register stages. Stage 1: classify, unpack, align. Stage 2: round, pack, flag. Latency = 2 cycles from accepted beat to out_valid when out_ready is held high.
  - Handshake: beat accepted when in_valid && in_ready; beat retired when out_valid && out_ready.
  - Stage k advances when empty or when its successor advances.
  - in_ready = !s1_valid || s1_advance (combinational from out_ready). Full throughput of 1 beat/cycle.
  - out_data and out_flags hold stable while out_valid && !out_ready.
- Config: cfg_fmt, cfg_rnd and cfg_sat are captured with each accepted beat and travel with it. A change applies only to beats accepted afterwards.
- Conversion, per lane, independent:
  - Zero (exp=0, mant=0): signed zero, flags 0.
  - BF16 subnormal inputs are treated as signed zero (DAZ), unf=0.
  - NaN input gives a canonical NaN with sign preserved: E4M3 S.1111.111, E5M2 S.11111.10. Flags 0.
  - Inf input:
    - E5M2: S.11111.00 if sat=0; max finite otherwise.
    - E4M3 has no Inf: S.1111.111 (NaN) if sat=0; max finite if sat=1. ovf=1 in all Inf cases.
  - Finite input: rebias, then round the 8-bit significand to 3 (E4M3) or 2 (E5M2) fraction bits.
    - Guard, round and sticky are computed over all discarded bits, including bits shifted out for subnormal results.
    - RNE: increment if G && (R || S || LSB).
    - Carry out of the mantissa increments the exponent; subnormal-to-normal carry is legal.
  - Overflow after rounding: exponent > max, or E4M3 exp=15 with mant=111.
    - Output max finite (E4M3 S.1111.110 = 448; E5M2 S.11110.11 = 57344) if sat=1.
    - Otherwise E4M3 NaN or E5M2 Inf. ovf=1.
  - Result magnitude rounds to zero from a nonzero input: signed zero, unf=1.
- Counter:
  - ovf_cnt adds popcount(ovf) of each retired beat, saturating at 2^CNT_W-1.
  - cnt_clr has priority over an increment in the same cycle: result 0, that cycle's events are dropped.

Test Plan:
- E4M3, RNE, LANES=4: lanes {0x3F80, 0xBF80, 0x0000, 0x8000} -> out lanes {0x38, 0xB8, 0x00, 0x80}, out_valid exactly 2 cycles after accept, flags 0.
- Rounding, E4M3: 0x3F98 (1.1875) -> 0x3A with RNE, 0x39 with truncate. 0x3F88 (1.0625, tie) -> 0x38 in both modes.
- Overflow, E4M3: 0x43E0 (448) -> 0x7E. 0x43F0 (480) -> 0x7E with ovf=1 when sat=1; 0x7F with ovf=1 when sat=0. E5M2: 0x7F80 (+Inf) -> 0x7C (sat=0), 0x7B (sat=1). ovf_cnt incremented per lane.
- Subnormal, E4M3: 0x3B00 (2^-9) -> 0x01. 0x3A80 (2^-10, tie) -> 0x00 with unf=1. NaN 0xFFC1 -> 0xFF.
- Backpressure: stream 8 beats with out_ready toggled 1,0,0,1,...
  - No beat lost or duplicated; order preserved.
  - out_data stable while stalled; in_ready low only when both stages are full and out_ready=0.
  - cfg_fmt flipped mid-stream affects only beats accepted after the flip.
- Reset and counter: assert rst_n low with 2 beats in flight -> out_valid=0 immediately, nothing emitted after release. With ovf_cnt preloaded to max via overflow beats it saturates; cnt_clr in the same cycle as an overflow beat -> ovf_cnt=0.

Source files
------------

// File: rtl/bf16_to_fp8_stream.sv
// Multi-lane BF16 to FP8 (E4M3/E5M2) stream converter with a two-stage valid/ready pipeline.
// Stage 1 classifies and aligns each lane, stage 2 rounds, packs and flags; config travels with each beat.
module bf16_to_fp8_stream #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_fmt,
  input  logic                 cfg_rnd,
  input  logic                 cfg_sat,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES*16-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LANES*8-1:0]   out_data,
  output logic [LANES*2-1:0]   out_flags,
  output logic [CNT_W-1:0]     ovf_cnt,
  input  logic                 cnt_clr
);

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_FIN  = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } cls_t;

  // base is the truncated FP8 magnitude {exp, frac}; g/r/st cover every discarded bit
  typedef struct packed {
    logic       sign;
    cls_t       cls;
    logic       pre_ovf;
    logic [6:0] base;
    logic       g;
    logic       r;
    logic       st;
  } s1_lane_t;

  function automatic s1_lane_t align_lane(input logic [15:0] x, input logic fmt);
    s1_lane_t          l;
    logic [7:0]        e;
    logic [6:0]        m;
    logic signed [9:0] te;
    logic [4:0]        sh;
    logic [4:0]        ef;
    logic [22:0]       ext;
    e  = x[14:7];
    m  = x[6:0];
    l  = '0;
    l.sign = x[15];
    te = $signed({2'b00, e}) - 10'sd127 + (fmt ? 10'sd15 : 10'sd7);
    if (e == 8'hff) begin
      l.cls = (m != 7'd0) ? CLS_NAN : CLS_INF;
    end else if (e == 8'h00) begin
      l.cls = CLS_ZERO;
    end else begin
      l.cls = CLS_FIN;
      // subnormal results shift the hidden bit into the fraction; beyond 16 only sticky remains
      if (te >= 10'sd1) begin
        sh = 5'd0;
        ef = te[4:0];
      end else if (te < -10'sd14) begin
        sh = 5'd16;
        ef = 5'd0;
      end else begin
        sh = 5'(10'sd1 - te);
        ef = 5'd0;
      end
      ext = 23'({1'b1, m, 16'b0} >> sh);
      l.pre_ovf = fmt ? (te > 10'sd30) : (te > 10'sd15);
      if (fmt) begin
        l.base = {ef, ext[22:21]};
        l.g    = ext[20];
        l.r    = ext[19];
        l.st   = |ext[18:0];
      end else begin
        l.base = {ef[3:0], ext[22:20]};
        l.g    = ext[19];
        l.r    = ext[18];
        l.st   = |ext[17:0];
      end
    end
    return l;
  endfunction

  // returns {ovf, unf, fp8}; a mantissa carry ripples into the exponent field naturally
  function automatic logic [9:0] round_pack(input s1_lane_t l, input logic fmt,
                                            input logic rnd, input logic sat);
    logic       inc;
    logic [7:0] sum;
    logic [6:0] mag;
    logic [6:0] ovf_mag;
    logic       ovf;
    logic       unf;
    inc     = !rnd && l.g && (l.r || l.st || l.base[0]);
    sum     = {1'b0, l.base} + {7'b0, inc};
    ovf_mag = sat ? (fmt ? 7'h7B : 7'h7E) : (fmt ? 7'h7C : 7'h7F);
    mag     = '0;
    ovf     = 1'b0;
    unf     = 1'b0;
    case (l.cls)
      CLS_NAN: mag = fmt ? 7'h7E : 7'h7F;
      CLS_INF: begin
        mag = ovf_mag;
        ovf = 1'b1;
      end
      CLS_FIN: begin
        if (l.pre_ovf || sum >= (fmt ? 8'h7C : 8'h7F)) begin
          mag = ovf_mag;
          ovf = 1'b1;
        end else begin
          mag = sum[6:0];
          unf = (sum == 8'h00);
        end
      end
      default: mag = '0;
    endcase
    return {ovf, unf, l.sign, mag};
  endfunction

  s1_lane_t [LANES-1:0] s1_lane;
  s1_lane_t [LANES-1:0] s1_lane_nxt;
  logic                 s1_valid;
  logic                 s1_fmt;
  logic                 s1_rnd;
  logic                 s1_sat;
  logic                 s1_adv;
  logic                 s2_adv;
  logic                 accept;
  logic [LANES*8-1:0]   s2_data_nxt;
  logic [LANES*2-1:0]   s2_flags_nxt;
  logic [CNT_W:0]       ovf_pc;
  logic [CNT_W:0]       cnt_sum;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_lane_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      s1_lane_nxt[i] = align_lane(in_data[16*i +: 16], cfg_fmt);
    end
  end

  always_comb begin
    s2_data_nxt  = '0;
    s2_flags_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      {s2_flags_nxt[2*i +: 2], s2_data_nxt[8*i +: 8]} =
        round_pack(s1_lane[i], s1_fmt, s1_rnd, s1_sat);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lane  <= '0;
      s1_fmt   <= 1'b0;
      s1_rnd   <= 1'b0;
      s1_sat   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_lane <= s1_lane_nxt;
        s1_fmt  <= cfg_fmt;
        s1_rnd  <= cfg_rnd;
        s1_sat  <= cfg_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= s2_data_nxt;
        out_flags <= s2_flags_nxt;
      end
    end
  end

  always_comb begin
    ovf_pc = '0;
    for (int i = 0; i < LANES; i++) begin
      ovf_pc = ovf_pc + (CNT_W+1)'(out_flags[2*i+1]);
    end
    cnt_sum = {1'b0, ovf_cnt} + ovf_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready) begin
      ovf_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_bf16_to_fp8_stream.sv
// Scoreboard bench for bf16_to_fp8_stream: a value-level reference picks the nearest FP8 code
// from a table of real magnitudes; a separate monitor checks beats, hold, in_ready and ovf_cnt.
module tb_bf16_to_fp8_stream;
  localparam int LANES = 4;
  localparam int CNT_W = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_fmt = 1'b0;
  logic                cfg_rnd = 1'b0;
  logic                cfg_sat = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*16-1:0] in_data = '0;
  logic                out_valid;
  logic                out_ready;
  logic [LANES*8-1:0]  out_data;
  logic [LANES*2-1:0]  out_flags;
  logic [CNT_W-1:0]    ovf_cnt;
  logic                cnt_clr = 1'b0;

  bf16_to_fp8_stream #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_fmt(cfg_fmt), .cfg_rnd(cfg_rnd), .cfg_sat(cfg_sat),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .ovf_cnt(ovf_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES*8-1:0] data;
    logic [LANES*2-1:0] flags;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   ready_mode = 0;
  real  fp8_val [2][128];

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int k = 0; k < n; k++) r = r * 2.0;
    else for (int k = 0; k < -n; k++) r = r / 2.0;
    return r;
  endfunction

  task automatic fill_table();
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 128; c++) begin
        int mb, bias, ef, fr;
        mb   = (f == 1) ? 2 : 3;
        bias = (f == 1) ? 15 : 7;
        ef   = c >> mb;
        fr   = c & ((1 << mb) - 1);
        if (ef == 0) fp8_val[f][c] = (real'(fr) / real'(1 << mb)) * pow2(1 - bias);
        else fp8_val[f][c] = (1.0 + real'(fr) / real'(1 << mb)) * pow2(ef - bias);
      end
    end
  endtask

  // {ovf, unf, fp8 byte}; the code just past max finite stands in for "rounded out of range"
  function automatic logic [9:0] ref_lane(input logic [15:0] x, input logic f,
                                          input logic r, input logic st);
    logic s;
    int   e, m, maxc, ovfc, c_lo, ch;
    real  v, dl, dh;
    s    = x[15];
    e    = int'(x[14:7]);
    m    = int'(x[6:0]);
    maxc = f ? 'h7B : 'h7E;
    ovfc = st ? maxc : (f ? 'h7C : 'h7F);
    if (e == 255) begin
      if (m != 0) return {2'b00, s, (f ? 7'h7E : 7'h7F)};
      return {2'b10, s, 7'(ovfc)};
    end
    if (e == 0) return {2'b00, s, 7'h00};
    v = (1.0 + real'(m) / 128.0) * pow2(e - 127);
    c_lo = 0;
    for (int c = 0; c <= maxc + 1; c++) if (fp8_val[f][c] <= v) c_lo = c;
    if (c_lo > maxc || fp8_val[f][c_lo] == v || r) begin
      ch = c_lo;
    end else begin
      dl = v - fp8_val[f][c_lo];
      dh = fp8_val[f][c_lo+1] - v;
      if (dl < dh) ch = c_lo;
      else if (dh < dl) ch = c_lo + 1;
      else ch = (c_lo % 2 == 0) ? c_lo : c_lo + 1;
    end
    if (ch > maxc) return {2'b10, s, 7'(ovfc)};
    return {1'b0, (ch == 0), s, 7'(ch)};
  endfunction

  function automatic exp_t model_beat(input logic [LANES*16-1:0] d, input logic f,
                                      input logic r, input logic st);
    exp_t       e;
    logic [9:0] l;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      l = ref_lane(d[16*i +: 16], f, r, st);
      e.data[8*i +: 8]  = l[7:0];
      e.flags[2*i +: 2] = l[9:8];
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_bf16();
    int k;
    logic [7:0] e;
    k = $urandom_range(0, 15);
    case (k)
      0: e = 8'h00;
      1: e = 8'hFF;
      2: e = 8'hFF;
      default: e = 8'($urandom_range(105, 146));
    endcase
    if (k == 1) return {1'($urandom_range(0, 1)), e, 7'h00};
    if (k == 2) return {1'($urandom_range(0, 1)), e, 7'($urandom_range(1, 127))};
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic send_beat(input logic [LANES*16-1:0] d, input logic f,
                           input logic r, input logic st);
    exp_t e;
    bit   acc;
    int   n;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    cfg_fmt  = f;
    cfg_rnd  = r;
    cfg_sat  = st;
    e   = model_beat(d, f, r, st);
    acc = 1'b0;
    n   = 0;
    while (!acc && n <= 100) begin
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) sb_q.push_back(e);
      else begin
        n++;
        @(negedge clk);
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual=stalled required=accepted");
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = (($time / 10) % 3 == 0);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    exp_t             e;
    logic             hold_v;
    logic [31:0]      hold_d;
    logic [7:0]       hold_f;
    longint           cnt_model;
    int               pc;
    hold_v = 1'b0;
    hold_d = '0;
    hold_f = '0;
    cnt_model = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        sb_q.delete();
        cnt_model = 0;
        hold_v = 1'b0;
      end else begin
        check("ovf_cnt", ovf_cnt, cnt_model);
        check("in_ready", in_ready, (sb_q.size() < 2) || out_ready);
        if (hold_v) check("hold", {out_valid, out_flags, out_data}, {1'b1, hold_f, hold_d});
        hold_v = out_valid && !out_ready;
        hold_d = out_data;
        hold_f = out_flags;
        pc = 0;
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: actual=%h required=none", out_data);
          end else begin
            e = sb_q.pop_front();
            check("beat", {out_flags, out_data}, {e.flags, e.data});
            for (int i = 0; i < LANES; i++) pc += int'(e.flags[2*i+1]);
          end
        end
        if (cnt_clr) cnt_model = 0;
        else if (cnt_model + pc > 65535) cnt_model = 65535;
        else cnt_model = cnt_model + pc;
      end
    end
  end

  initial begin
    fill_table();
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_flags", out_flags, 0);
    check("rst_ovf_cnt", ovf_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", in_ready, 1);

    send_beat({16'h8000, 16'h0000, 16'hBF80, 16'h3F80}, 1'b0, 1'b0, 1'b0);
    #1;
    check("latency_c1", out_valid, 0);
    idle();
    @(posedge clk);
    #1;
    check("latency_c2", out_valid, 1);

    send_beat({16'h3F88, 16'h3F98, 16'h3F88, 16'h3F98}, 1'b0, 1'b0, 1'b0);
    send_beat({16'h3F88, 16'h3F98, 16'h3F88, 16'h3F98}, 1'b0, 1'b1, 1'b0);
    send_beat({16'hC3F0, 16'h43F0, 16'hC3E0, 16'h43E0}, 1'b0, 1'b0, 1'b1);
    send_beat({16'hC3F0, 16'h43F0, 16'hC3E0, 16'h43E0}, 1'b0, 1'b0, 1'b0);
    send_beat({16'hFF80, 16'h7F80, 16'hFF80, 16'h7F80}, 1'b1, 1'b0, 1'b0);
    send_beat({16'hFF80, 16'h7F80, 16'hFF80, 16'h7F80}, 1'b1, 1'b0, 1'b1);
    send_beat({16'h0001, 16'hFFC1, 16'h3A80, 16'h3B00}, 1'b0, 1'b0, 1'b0);
    send_beat({16'h7F80, 16'h7FC0, 16'h3A80, 16'h3B00}, 1'b0, 1'b1, 1'b0);
    idle();
    drain();

    ready_mode = 2;
    for (int k = 0; k < 400; k++) begin
      send_beat({rand_bf16(), rand_bf16(), rand_bf16(), rand_bf16()},
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    idle();
    drain();

    ready_mode = 1;
    for (int k = 0; k < 8; k++) begin
      send_beat({rand_bf16(), rand_bf16(), 16'h3F98, 16'h43F0}, (k >= 4), 1'b0, 1'b1);
    end
    idle();
    drain();

    ready_mode = 3;
    send_beat({16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80}, 1'b0, 1'b0, 1'b0);
    send_beat({16'h7F80, 16'h7F80, 16'h7F80, 16'h7F80}, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_flush_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("no_emit_after_rst", out_valid, 0);
    end

    for (int k = 0; k < 16384; k++) send_beat({4{16'h7F80}}, 1'b0, 1'b0, 1'b1);
    idle();
    drain();
    #1;
    check("ovf_cnt_sat", ovf_cnt, 16'hFFFF);
    send_beat({4{16'hFF80}}, 1'b1, 1'b0, 1'b1);
    idle();
    drain();
    #1;
    check("ovf_cnt_hold_sat", ovf_cnt, 16'hFFFF);

    send_beat({4{16'h7F80}}, 1'b0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_priority", ovf_cnt, 0);
    check("clr_beat_retired", out_valid, 0);
    @(negedge clk);
    cnt_clr = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
